// File: rtl/delivery_game_sched_pkg.sv
// Shared types for the delivery game measurement scheduler: FSM state codes
// (also exported on db_estado) and velocity-level limits.
package delivery_game_sched_pkg;
  localparam int VEL_W   = 3;
  localparam int VEL_MAX = 7;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RST    = 4'd1,
    S_START1 = 4'd2,
    S_WAIT1  = 4'd3,
    S_GAP    = 4'd4,
    S_START2 = 4'd5,
    S_WAIT2  = 4'd6,
    S_CALC   = 4'd7,
    S_DONE   = 4'd8,
    S_FAIL   = 4'd9
  } state_e;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/delivery_game_sensor_sched_if.sv
// Game-UC / ultrasonic-side signals of the scheduler. master = requester and
// sensor side (drives request and samples), slave = the scheduler.
interface delivery_game_sensor_sched_if #(parameter int DIST_W = 12);
  import delivery_game_sched_pkg::*;

  logic              get_velocity;
  logic              medida_pronto;
  logic [DIST_W-1:0] medida;
  logic              reset_ultrasonico;
  logic              medir;
  logic [VEL_W-1:0]  velocity;
  logic              velocity_ready;
  logic              velocity_timeout;
  logic              busy;
  logic [3:0]        db_estado;

  modport master (
    output get_velocity, medida_pronto, medida,
    input  reset_ultrasonico, medir, velocity, velocity_ready,
           velocity_timeout, busy, db_estado
  );

  modport slave (
    input  get_velocity, medida_pronto, medida,
    output reset_ultrasonico, medir, velocity, velocity_ready,
           velocity_timeout, busy, db_estado
  );
endinterface

// File: rtl/delivery_game_sched_timer.sv
// Loadable down-counter shared by sample timeout and inter-sample gap.
// expired is high while the count is 1, i.e. on the Nth cycle after a load of N.
module delivery_game_sched_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)            cnt_d = value;
    else if (cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == W'(1));
endmodule

// File: rtl/delivery_game_sensor_sched.sv
// Velocity measurement scheduler: sensor reset, two timed samples with retry,
// drop -> 3-bit level. Optional DELIVERY_SCHED_FILTER_EN averages with last raw level.
module delivery_game_sensor_sched
  import delivery_game_sched_pkg::*;
#(
  parameter int DIST_W         = 12,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int GAP_CYCLES     = 2500000,
  parameter int MAX_RETRY      = 2,
  parameter int VEL_SHIFT      = 2
) (
  input logic clock,
  input logic reset,
  delivery_game_sensor_sched_if.slave bus
);
  localparam int TW = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

  state_e            state_q, state_d;
  logic [DIST_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [1:0]        retry_q, retry_d;
  logic [VEL_W-1:0]  vel_q, vel_d, vel_calc, level;
  logic              rst_us_q, medir_q, ready_q, tout_q;
  logic              tmr_load, tmr_expired;
  logic [TW-1:0]     tmr_val;
  logic [DIST_W-1:0] diff, shifted;

  delivery_game_sched_timer #(.W(TW)) u_timer (
    .clock(clock), .reset(reset), .load(tmr_load), .value(tmr_val), .expired(tmr_expired)
  );

  always_comb begin
    diff    = d1_q - d2_q;
    shifted = diff >> VEL_SHIFT;
    if (d2_q >= d1_q)                      level = '0;
    else if (shifted > DIST_W'(VEL_MAX))   level = VEL_W'(VEL_MAX);
    else                                   level = shifted[VEL_W-1:0];
  end

`ifdef DELIVERY_SCHED_FILTER_EN
  logic [VEL_W-1:0] prev_q, prev_d;
  logic [VEL_W:0]   sum;
  always_comb begin
    sum      = {1'b0, level} + {1'b0, prev_q} + (VEL_W+1)'(1);
    vel_calc = sum[VEL_W:1];
    prev_d   = (state_q == S_CALC) ? level : prev_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev_q <= '0;
    else        prev_q <= prev_d;
  end
`else
  assign vel_calc = level;
`endif

  always_comb begin
    state_d  = state_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    retry_d  = retry_q;
    vel_d    = vel_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE:   if (bus.get_velocity) state_d = S_RST;
      S_RST: begin
        retry_d = '0;
        state_d = S_START1;
      end
      S_START1, S_START2: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TIMEOUT_CYCLES);
        state_d  = (state_q == S_START1) ? S_WAIT1 : S_WAIT2;
      end
      S_WAIT1, S_WAIT2: begin
        // A done arriving on the expiry cycle is still accepted.
        if (bus.medida_pronto) begin
          retry_d = '0;
          if (state_q == S_WAIT1) begin
            d1_d     = bus.medida;
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_CYCLES);
            state_d  = S_GAP;
          end else begin
            d2_d    = bus.medida;
            state_d = S_CALC;
          end
        end else if (tmr_expired) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            state_d = (state_q == S_WAIT1) ? S_START1 : S_START2;
          end else begin
            vel_d   = '0;
            state_d = S_FAIL;
          end
        end
      end
      S_GAP:    if (tmr_expired) state_d = S_START2;
      S_CALC: begin
        vel_d   = vel_calc;
        state_d = S_DONE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      d1_q     <= '0;
      d2_q     <= '0;
      retry_q  <= '0;
      vel_q    <= '0;
      rst_us_q <= 1'b0;
      medir_q  <= 1'b0;
      ready_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      retry_q  <= retry_d;
      vel_q    <= vel_d;
      rst_us_q <= (state_d == S_RST);
      medir_q  <= (state_d == S_START1) || (state_d == S_START2);
      ready_q  <= (state_d == S_DONE);
      tout_q   <= (state_d == S_FAIL);
    end
  end

  assign bus.reset_ultrasonico = rst_us_q;
  assign bus.medir             = medir_q;
  assign bus.velocity          = vel_q;
  assign bus.velocity_ready    = ready_q;
  assign bus.velocity_timeout  = tout_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.db_estado         = state_q;
endmodule

// File: tb/tb_delivery_game_sensor_sched.sv
// Randomized bench for delivery_game_sensor_sched: a responder reacts to medir
// pulses and a timeline model predicts every pulse cycle and the velocity level.
module tb_delivery_game_sensor_sched;
  localparam int T  = 20;
  localparam int G  = 10;
  localparam int VS = 2;
  localparam int MR = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  delivery_game_sensor_sched_if #(.DIST_W(12)) bus();

  delivery_game_sensor_sched #(
    .DIST_W(12), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .MAX_RETRY(MR), .VEL_SHIFT(VS)
  ) u_dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int prev_lvl = 0;

  function automatic int raw_level(int d1, int d2);
    int lv;
    if (d2 >= d1) return 0;
    lv = (d1 - d2) / (1 << VS);
    return (lv > 7) ? 7 : lv;
  endfunction

  // One full request. nfN = attempts left unanswered for sample N (>MR means
  // the sample never succeeds); dlyN = cycles from the answered medir to done.
  task automatic run_req(input string nm, input int d1, input int d2,
                         input int nf1, input int dly1, input int nf2, input int dly2,
                         input bit noise);
    int exp_m[$];
    int obs_m[$];
    int last, c1, end_c, exp_vel, lv;
    bit fail;
    int rdy_cnt, rdy_cyc, to_cnt, to_cyc, rst_cnt, rst_cyc, busy_bad, db_end;
    int vel_obs, vel_after, sample, att, resp_cyc, inj, bad_m;

    fail = 0; last = 0; end_c = 0;
    for (int a = 0; a <= ((nf1 > MR) ? MR : nf1); a++) begin
      last = 2 + a * (T + 1);
      exp_m.push_back(last);
    end
    if (nf1 > MR) begin
      fail = 1; end_c = last + T + 1;
    end else begin
      c1 = last + dly1;
      for (int a = 0; a <= ((nf2 > MR) ? MR : nf2); a++) begin
        last = c1 + G + 1 + a * (T + 1);
        exp_m.push_back(last);
      end
      if (nf2 > MR) begin fail = 1; end_c = last + T + 1; end
      else end_c = last + dly2 + 2;
    end
    lv = raw_level(d1, d2);
`ifdef DELIVERY_SCHED_FILTER_EN
    exp_vel = fail ? 0 : (lv + prev_lvl + 1) / 2;
`else
    exp_vel = fail ? 0 : lv;
`endif

    rdy_cnt = 0; rdy_cyc = -1; to_cnt = 0; to_cyc = -1; rst_cnt = 0; rst_cyc = -1;
    busy_bad = 0; db_end = -1; vel_obs = -1; vel_after = -1;
    sample = 1; att = 0; resp_cyc = -1;
    inj = noise ? int'($urandom_range(3, end_c)) : -1;

    @(posedge clock); #1;
    bus.get_velocity = 1'b1;
    for (int cyc = 1; cyc <= end_c + 1; cyc++) begin
      @(posedge clock); #1;
      bus.get_velocity  = (cyc == inj);
      bus.medida_pronto = 1'b0;
      if (bus.medir) begin
        obs_m.push_back(cyc);
        if (att == ((sample == 1) ? nf1 : nf2))
          resp_cyc = cyc + ((sample == 1) ? dly1 : dly2);
        att++;
      end
      if (cyc == resp_cyc) begin
        bus.medida_pronto = 1'b1;
        bus.medida        = 12'((sample == 1) ? d1 : d2);
        sample++; att = 0; resp_cyc = -1;
      end else if (noise && cyc == 1) begin
        bus.medida_pronto = 1'b1;
        bus.medida        = 12'($urandom_range(0, 4095));
      end
      if (bus.reset_ultrasonico) begin rst_cnt++; rst_cyc = cyc; end
      if (bus.velocity_ready)    begin rdy_cnt++; rdy_cyc = cyc; vel_obs = int'(bus.velocity); end
      if (bus.velocity_timeout)  begin to_cnt++; to_cyc = cyc; vel_obs = int'(bus.velocity); end
      if (cyc <= end_c && !bus.busy) busy_bad++;
      if (cyc == end_c + 1) begin
        if (bus.busy) busy_bad++;
        vel_after = int'(bus.velocity);
      end
      if (cyc == end_c) db_end = int'(bus.db_estado);
    end
    bus.get_velocity  = 1'b0;
    bus.medida_pronto = 1'b0;

    bad_m = (obs_m.size() != exp_m.size()) ? 1 : 0;
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++)
      if (obs_m[i] != exp_m[i]) bad_m++;
    checks++;
    if (bad_m != 0) begin
      failures++;
      $display("FAIL %s medir_times got_count=%0d exp_count=%0d first_got=%0d first_exp=%0d",
               nm, obs_m.size(), exp_m.size(), (obs_m.size() > 0) ? obs_m[0] : -1, exp_m[0]);
    end
    checks++;
    if (rst_cnt !== 1 || rst_cyc !== 1) begin
      failures++;
      $display("FAIL %s reset_us got_count=%0d got_cyc=%0d exp_count=1 exp_cyc=1", nm, rst_cnt, rst_cyc);
    end
    checks++;
    if (fail ? (to_cnt !== 1 || to_cyc !== end_c || rdy_cnt !== 0)
             : (rdy_cnt !== 1 || rdy_cyc !== end_c || to_cnt !== 0)) begin
      failures++;
      $display("FAIL %s result_pulse ready=%0d@%0d timeout=%0d@%0d exp_%s@%0d",
               nm, rdy_cnt, rdy_cyc, to_cnt, to_cyc, fail ? "timeout" : "ready", end_c);
    end
    checks++;
    if (vel_obs !== exp_vel || vel_after !== exp_vel) begin
      failures++;
      $display("FAIL %s velocity got=%0d held=%0d exp=%0d", nm, vel_obs, vel_after, exp_vel);
    end
    checks++;
    if (busy_bad !== 0) begin
      failures++;
      $display("FAIL %s busy bad_cycles=%0d exp=0", nm, busy_bad);
    end
    checks++;
    if (db_end !== (fail ? 9 : 8)) begin
      failures++;
      $display("FAIL %s db_estado_end got=%0d exp=%0d", nm, db_end, fail ? 9 : 8);
    end
    if (!fail) prev_lvl = lv;
  endtask

  task automatic test_reset();
    bus.get_velocity = 1'b0; bus.medida_pronto = 1'b0; bus.medida = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus.reset_ultrasonico, bus.medir, bus.velocity_ready, bus.velocity_timeout, bus.busy} !== 5'b0
        || bus.velocity !== 3'd0 || bus.db_estado !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got pulses=%b vel=%0d db=%0d exp all 0",
               {bus.reset_ultrasonico, bus.medir, bus.velocity_ready, bus.velocity_timeout, bus.busy},
               bus.velocity, bus.db_estado);
    end
    reset = 1'b1;
    prev_lvl = 0;
  endtask

  task automatic test_nominal();
    run_req("nominal", 100, 88, 0, 5, 0, 5, 0);
  endtask

  task automatic test_levels();
    run_req("saturate", 200, 100, 0, 4, 0, 7, 0);
    run_req("receding", 50, 60, 0, 2, 0, 1, 0);
    run_req("equal", 40, 40, 0, 1, 0, 3, 0);
  endtask

  task automatic test_retry();
    run_req("retry1", 300, 270, 1, 3, 0, 5, 0);
    run_req("retry2", 300, 290, 0, 6, 2, 2, 0);
  endtask

  task automatic test_fail();
    run_req("fail_s1", 100, 10, 3, 1, 0, 1, 0);
    run_req("fail_s2", 100, 10, 0, 4, 3, 1, 0);
  endtask

  task automatic test_coincide();
    run_req("coincide", 500, 480, 0, T, 1, T, 1);
  endtask

  task automatic test_async_reset();
    bit seen;
    run_req("pre_reset", 1000, 900, 0, 2, 0, 2, 0);
    @(posedge clock); #1;
    bus.get_velocity = 1'b1;
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      for (int c = 0; c < 60 && !seen; c++) begin
        @(posedge clock); #1;
        bus.get_velocity = 1'b0;
        bus.medida_pronto = 1'b0;
        if (bus.medir) seen = 1;
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL async_setup medir%0d got=none exp=pulse", k + 1);
      end
      if (k == 0) begin
        @(posedge clock); #1;
        bus.medida = 12'd700; bus.medida_pronto = 1'b1;
        @(posedge clock); #1;
        bus.medida_pronto = 1'b0;
      end
    end
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.reset_ultrasonico, bus.medir, bus.velocity_ready, bus.velocity_timeout, bus.busy} !== 5'b0
        || bus.velocity !== 3'd0 || bus.db_estado !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got pulses=%b vel=%0d db=%0d exp all 0",
               {bus.reset_ultrasonico, bus.medir, bus.velocity_ready, bus.velocity_timeout, bus.busy},
               bus.velocity, bus.db_estado);
    end
    #2;
    reset = 1'b1;
    prev_lvl = 0;
    run_req("post_reset_lvl3", 100, 88, 0, 5, 0, 5, 0);
    run_req("post_reset_lvl6", 100, 76, 0, 3, 0, 4, 0);
  endtask

  task automatic test_random();
    int d1, d2, nf1, nf2;
    for (int i = 0; i < 8; i++) begin
      d1  = int'($urandom_range(0, 4095));
      d2  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : d1 - int'($urandom_range(0, 40));
      if (d2 < 0) d2 = 0;
      nf1 = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      nf2 = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      run_req($sformatf("random%0d", i), d1, d2, nf1, int'($urandom_range(1, T)),
              nf2, int'($urandom_range(1, T)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_levels();
    test_retry();
    test_fail();
    test_coincide();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
